tff_bank: RTL and testbench
===========================

# tff_bank

Multi-channel debounced toggle bank. It is the parametrised successor to the single-button toggle flip-flop. Each of CHANNELS button inputs is synchronised, debounced with a stable-count filter, and edge-detected. Each channel then drives a toggle or follow output register to the board LEDs. The bank runs on the divided clock from the clock divider and sits between the board buttons and the LED pins.

## Interface
Parameters:
- CHANNELS, 5, number of independent button/LED channels (1..16)
- STABLE_CNT, 4, consecutive clk_out cycles a changed input must persist before acceptance (>=1)
- SYNC_STAGES, 2, synchroniser flops per input (>=2)
- TOGGLE_MASK, all ones, bit i=1: channel i toggles on press; bit i=0: channel i follows the debounced level
- LONG_CNT, 16, held cycles for long-press clear (used only with the macro, >=1)

Ports:
- clk_out  in  1  divided system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- btn  in  CHANNELS  raw, asynchronous button levels
- led  out  CHANNELS  channel outputs
- press  out  CHANNELS  one-cycle pulse per accepted rising debounced edge
- long_press  out  CHANNELS  one-cycle pulse on long-press clear; constant 0 without macro

## Operation
- Synchroniser: per channel, SYNC_STAGES flops; last stage is sync[i].
- Debounce state per channel: db[i] and counter cnt[i], width clog2(STABLE_CNT+1).
  - sync==db: cnt<=0.
  - sync!=db and cnt==STABLE_CNT-1: db<=sync, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Any return to sync==db before acceptance discards the partial count (glitch rejection).
- press[i] is registered and high for exactly one cycle after db[i] goes 0->1. Falling db edges produce no pulse.
- Toggle channel (TOGGLE_MASK[i]=1): led[i] inverts on the edge where press[i] is generated.
- Follow channel (TOGGLE_MASK[i]=0): led[i] <= db[i].
- Channels are fully independent. Simultaneous presses on any subset act on all of them in the same cycle.

## Timing
- Reset values: every synchroniser flop, db, cnt, hold counter, led, press and long_press are 0.
- Reset takes effect immediately. A reset mid-debounce or mid-hold discards all progress.
- After rst deasserts with btn held high, the press is accepted after normal debounce latency.
- Latency (SYNC_STAGES=2): btn first sampled high at edge k and held:
  - sync high after edge k+1.
  - db high after edge k+1+STABLE_CNT.
  - press and led update at edge k+2+STABLE_CNT.
- Release latency is symmetric for db and follow-mode led.
- A pulse shorter than STABLE_CNT cycles at sync is never accepted.
- Repeated presses need at least one accepted release between them. Holding gives one toggle only.

## Configuration
- Macro TFF_BANK_LONGPRESS_EN.
- Defined:
  - Per channel, a saturating hold counter (width clog2(LONG_CNT+1)) increments each cycle db[i]=1 and clears when db[i]=0.
  - On the edge the counter reaches LONG_CNT, led[i]<=0 and long_press[i] pulses for one cycle.
  - Continued holding does not repeat the clear.
  - If the clear and a press coincide (only possible at LONG_CNT=1), the clear wins.
- Not defined: no hold counters; long_press tied to 0; led behaviour unaffected.

## Structure
- Package tff_bank_pkg: mode constants MODE_FOLLOW=0 and MODE_TOGGLE=1, default parameter values, and a clog2 width helper function.
- Sub-module tff_bank_ch: one channel containing the synchroniser, debounce counter, edge detect, output register and optional hold counter.
- tff_bank generates CHANNELS instances, passing TOGGLE_MASK[i] as that instance's mode.

## Test plan
All scenarios use STABLE_CNT=4 and LONG_CNT=16 unless noted.
- Clean press: btn[0] high 10 cycles from edge k -> press[0] pulses and led[0] 0->1 at edge k+6; no further change during the hold.
- Bounce: btn[1] high 3 cycles, low 1, high 3, then low -> no press and led[1] stays 0.
- Follow mode: TOGGLE_MASK=5'b11110, btn[0] high 8 cycles -> led[0] rises at k+6 and falls 6 cycles after release.
- Simultaneous: btn=5'b10101 held 8 cycles -> press=5'b10101 for one cycle; led=5'b10101.
- Reset mid-operation: rst pulsed at k+3 during a press -> all outputs 0; with btn still high, acceptance occurs 6 cycles after the first post-reset sampling edge.
- Long press (macro defined): led[2]=1 then btn[2] held 30 cycles -> toggle to 0 at k+6, led[2]=1 after the second press, cleared at 16 held cycles with one long_press[2] pulse.

Source files
------------

// File: rtl/tff_bank_pkg.sv
// tff_bank shared definitions: channel modes, default parameters
// and the counter width helper.
package tff_bank_pkg;

  typedef enum logic {
    MODE_FOLLOW = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

  localparam int unsigned DEF_CHANNELS    = 5;
  localparam int unsigned DEF_STABLE_CNT  = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_LONG_CNT    = 16;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/tff_bank_ch.sv
// One debounced toggle/follow channel: synchroniser, stable-count
// filter, rising-edge pulse, LED register; hold clear if TFF_BANK_LONGPRESS_EN.
module tff_bank_ch
  import tff_bank_pkg::*;
#(
  parameter mode_e       MODE        = MODE_TOGGLE,
  parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
`ifdef TFF_BANK_LONGPRESS_EN
  ,
  parameter int unsigned LONG_CNT    = DEF_LONG_CNT
`endif
) (
  input  logic clk_out,
  input  logic rst,
  input  logic btn,
  output logic led,
  output logic press,
  output logic long_press
);

  localparam int unsigned CW = clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   db;
  logic                   db_d;
  logic [CW-1:0]          cnt;
  logic                   rise;
  logic                   clr;
  logic                   led_nxt;

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A level must differ from db for STABLE_CNT straight cycles;
  // any agreement in between restarts the count.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (sync == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rise = db & ~db_d;

  always_comb begin
    led_nxt = led;
    if (MODE == MODE_TOGGLE) begin
      if (rise) led_nxt = ~led;
    end else begin
      led_nxt = db;
    end
    if (clr) led_nxt = 1'b0;
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      db_d  <= 1'b0;
      press <= 1'b0;
      led   <= 1'b0;
    end else begin
      db_d  <= db;
      press <= rise;
      led   <= led_nxt;
    end
  end

`ifdef TFF_BANK_LONGPRESS_EN
  localparam int unsigned HW = clog2(LONG_CNT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CNT);

  logic [HW-1:0] hold;

  // Saturates at LONG_CNT so a continued hold clears only once.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst)                   hold <= '0;
    else if (!db)              hold <= '0;
    else if (hold != HOLD_MAX) hold <= hold + 1'b1;
  end

  assign clr = db && (hold == HOLD_LAST);

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) long_press <= 1'b0;
    else     long_press <= clr;
  end
`else
  assign clr        = 1'b0;
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/tff_bank.sv
// Bank of CHANNELS debounced toggle/follow channels driving LEDs.
// Long-press clear is built only with TFF_BANK_LONGPRESS_EN.
module tff_bank
  import tff_bank_pkg::*;
#(
  parameter int unsigned         CHANNELS    = DEF_CHANNELS,
  parameter int unsigned         STABLE_CNT  = DEF_STABLE_CNT,
  parameter int unsigned         SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [CHANNELS-1:0] TOGGLE_MASK = '1,
  parameter int unsigned         LONG_CNT    = DEF_LONG_CNT
) (
  input  logic                clk_out,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] long_press
);

  if (CHANNELS < 1 || CHANNELS > 16 || STABLE_CNT < 1 ||
      SYNC_STAGES < 2 || LONG_CNT < 1) begin : g_bad_cfg
    $error("tff_bank: parameter out of range");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tff_bank_ch #(
      .MODE        (mode_e'(TOGGLE_MASK[i])),
      .STABLE_CNT  (STABLE_CNT),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef TFF_BANK_LONGPRESS_EN
      ,
      .LONG_CNT    (LONG_CNT)
`endif
    ) u_ch (
      .clk_out    (clk_out),
      .rst        (rst),
      .btn        (btn[i]),
      .led        (led[i]),
      .press      (press[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_tff_bank.sv
// Directed bench for tff_bank: STABLE_CNT=4, LONG_CNT=16,
// channel 0 in follow mode, channels 1-4 toggle.
module tb_tff_bank;

  localparam int N = 5;

  logic         clk_out = 1'b0;
  logic         rst     = 1'b1;
  logic [N-1:0] btn     = '0;
  logic [N-1:0] led;
  logic [N-1:0] press;
  logic [N-1:0] long_press;
  logic [N-1:0] p_or;
  logic [N-1:0] l_or;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_out = ~clk_out;

  tff_bank #(
    .CHANNELS    (N),
    .STABLE_CNT  (4),
    .SYNC_STAGES (2),
    .TOGGLE_MASK (5'b11110),
    .LONG_CNT    (16)
  ) dut (
    .clk_out    (clk_out),
    .rst        (rst),
    .btn        (btn),
    .led        (led),
    .press      (press),
    .long_press (long_press)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_out);
  endtask

  // Steps n cycles, OR-ing press and long_press seen at each negedge.
  task automatic run(input int n, output logic [N-1:0] po,
                     output logic [N-1:0] lo);
    po = '0;
    lo = '0;
    repeat (n) begin
      @(negedge clk_out);
      po |= press;
      lo |= long_press;
    end
  endtask

  initial begin
    // reset
    step(3);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_press", 32'(press), 32'h0);
    chk("rst_long", 32'(long_press), 32'h0);
    rst = 1'b0;
    step(2);

    // clean press on toggle channel 3, held 10 sampling edges
    btn = 5'b01000;
    step(6);
    chk("clean_k5_led", 32'(led), 32'h00);
    chk("clean_k5_press", 32'(press), 32'h00);
    step(1);
    chk("clean_k6_press", 32'(press), 32'h08);
    chk("clean_k6_led", 32'(led), 32'h08);
    step(1);
    chk("clean_k7_press", 32'(press), 32'h00);
    run(2, p_or, l_or);
    btn = '0;
    chk("clean_hold_once", 32'(p_or), 32'h00);
    run(12, p_or, l_or);
    chk("clean_rel_press", 32'(p_or), 32'h00);
    chk("clean_rel_led", 32'(led), 32'h08);

    // bounce on channel 1: 3 high, 1 low, 3 high
    btn = 5'b00010;
    run(3, p_or, l_or);
    btn = '0;
    step(1);
    btn = 5'b00010;
    step(3);
    btn = '0;
    run(12, l_or, p_or);
    chk("bounce_press", 32'(l_or), 32'h00);
    chk("bounce_led", 32'(led), 32'h08);

    // follow channel 0 held 8 sampling edges
    btn = 5'b00001;
    step(6);
    chk("follow_k5_led", 32'(led), 32'h08);
    step(1);
    chk("follow_k6_led", 32'(led), 32'h09);
    chk("follow_k6_press", 32'(press), 32'h01);
    step(1);
    btn = '0;
    step(6);
    chk("follow_r5_led", 32'(led), 32'h09);
    step(1);
    chk("follow_r6_led", 32'(led), 32'h08);

    // simultaneous press on 0, 2, 4
    btn = 5'b10101;
    step(6);
    chk("simul_k5_press", 32'(press), 32'h00);
    step(1);
    chk("simul_k6_press", 32'(press), 32'h15);
    chk("simul_k6_led", 32'(led), 32'h1d);
    step(1);
    chk("simul_k7_press", 32'(press), 32'h00);
    btn = '0;
    step(12);
    chk("simul_rel_led", 32'(led), 32'h1c);

    // reset in the middle of a press on channel 2
    btn = 5'b00100;
    step(3);
    rst = 1'b1;
    #1;
    chk("midrst_led", 32'(led), 32'h00);
    chk("midrst_press", 32'(press), 32'h00);
    step(1);
    rst = 1'b0;
    step(6);
    chk("postrst_p5_led", 32'(led), 32'h00);
    step(1);
    chk("postrst_p6_press", 32'(press), 32'h04);
    chk("postrst_p6_led", 32'(led), 32'h04);
    step(1);
    chk("postrst_p7_press", 32'(press), 32'h00);

`ifdef TFF_BANK_LONGPRESS_EN
    run(13, p_or, l_or);
    chk("long_pre_lp", 32'(l_or), 32'h00);
    chk("long_pre_press", 32'(p_or), 32'h00);
    chk("long_pre_led", 32'(led), 32'h04);
    step(1);
    chk("long_clr_lp", 32'(long_press), 32'h04);
    chk("long_clr_led", 32'(led), 32'h00);
    run(10, p_or, l_or);
    chk("long_once", 32'(l_or), 32'h00);
    chk("long_after_led", 32'(led), 32'h00);
`else
    run(20, p_or, l_or);
    chk("hold_lp_zero", 32'(l_or), 32'h00);
    chk("hold_press_once", 32'(p_or), 32'h00);
    chk("hold_led", 32'(led), 32'h04);
`endif
    btn = '0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
